bargraph_level_driver: RTL and testbench
========================================

# bargraph_level_driver

Consumes the per-transition step pulses (Shift) and direction (Dir) produced by the quadrature decoder, accumulates them into whole encoder detents, and maintains a saturating (or optionally wrapping) level counter. Drives the LED bargraph as a registered thermometer ("bar") or one-hot ("dot") pattern. Sits directly downstream of the decoder in the rotary_bargraph top level, on the same clock.

## Interface
- LEDS, default 8: number of bargraph LEDs; level range is 0..LEDS.
- STEPS_PER_DETENT, default 4: Shift pulses per mechanical detent; power of two, 1..8.
- WRAP, default 0: 0 = saturate at ends, 1 = wrap LEDS↔0.
- Clk  in  1: system clock; all logic on rising edge.
- Reset  in  1: synchronous, active-high reset.
- Shift  in  1: one-cycle step pulse from the decoder; may assert on consecutive cycles.
- Dir  in  1: direction, qualified by Shift; 1 = up (increment), 0 = down.
- Mode  in  1: 0 = bar display, 1 = dot display.
- Leds  out  LEDS: registered LED drive, bit 0 = lowest LED.
- Level  out  $clog2(LEDS+1): current level, registered.
- Limit  out  1: one-cycle pulse when a completed detent is blocked at an end (WRAP=0 only).

## Operation
- Detent accumulator: signed count Sub, range −STEPS_PER_DETENT..+STEPS_PER_DETENT.
  - Shift&Dir: Sub+1; Shift&!Dir: Sub−1; no Shift: hold.
  - Reversal mid-detent cancels naturally (e.g. +1,+1,−1 leaves Sub=+1).
  - Sub reaching +STEPS_PER_DETENT → issue step-up, Sub←0 in the same edge. Reaching −STEPS_PER_DETENT → step-down, Sub←0.
- Level update on step:
  - Up: Level<LEDS → Level+1; Level==LEDS → WRAP ? 0 : hold and pulse Limit.
  - Down: Level>0 → Level−1; Level==0 → WRAP ? LEDS : hold and pulse Limit.
  - A blocked step still clears Sub to 0.
- LED decode (from next-state Level and current Mode):
  - Bar: Leds[i] = (i < Level).
  - Dot: Leds[i] = (i == Level−1); Level 0 → all off.
- Mode is a static, level-sensitive input; no state machine beyond counters.
- Reset (any cycle, including mid-detent): Sub=0, Level=0, Leds=0, Limit=0. Reset overrides a coincident Shift.
- Arithmetic: Sub width $clog2(STEPS_PER_DETENT)+2 bits signed; Level compared against LEDS at full width, no overflow possible.

## Timing
- Shift sampled at edge n completing a detent → Level, Leds, Limit valid after edge n (visible in cycle n+1); single-cycle latency, no handshake.
- Limit high exactly one cycle per blocked detent; low otherwise.
- Back-to-back Shift pulses every cycle accepted with no loss; STEPS_PER_DETENT consecutive up-pulses yield exactly one step.
- Mode change reflected on Leds one cycle after the edge that samples it.
- Reset asserted at edge n → all outputs zero in cycle n+1; first Shift counted is the one sampled at the first edge with Reset low.

## Structure
- Shared package rotary_pkg: LEDS default, STEPS_PER_DETENT default, MODE_BAR/MODE_DOT constants, level width function.
- One sub-module: detent_accumulator (Shift, Dir → step_up/step_down pulses, owns Sub). Level counter and LED decode stay in the top.

## Test plan
- Reset, then 4 Shift pulses with Dir=1 (defaults) → Level 0→1 after 4th pulse, Leds=8'b0000_0001, Limit=0.
- Shift pattern +1,+1,−1,+1,+1,+1 → one step only after final pulse; Sub back to 0.
- 36 up-pulses from Level 0, WRAP=0 → Level saturates at 8, Leds=8'hFF, Limit pulses once on the 9th detent; 4 down-pulses → Level 7.
- WRAP=1: at Level 8 one up-detent → Level 0, Leds=0; one down-detent → Level 8, no Limit.
- Mode=1 at Level 3 → Leds=8'b0000_0100 next cycle; Mode=0 → 8'b0000_0111.
- Reset asserted with Sub=+3, Level=5 → all outputs 0 next cycle; single following up-pulse does not step.

Source files
------------

// File: rtl/rotary_pkg.sv
// rotary_pkg: shared defaults and helpers for the rotary bargraph datapath
package rotary_pkg;
    localparam int LEDS_DEFAULT = 8;
    localparam int STEPS_DEFAULT = 4;
    localparam logic MODE_BAR = 1'b0;
    localparam logic MODE_DOT = 1'b1;

    function automatic int level_width(input int leds);
        return $clog2(leds + 1);
    endfunction
endpackage

// File: rtl/detent_accumulator.sv
// detent_accumulator: folds decoder step pulses into whole-detent step_up/step_down pulses
module detent_accumulator #(
    parameter int STEPS_PER_DETENT = rotary_pkg::STEPS_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Shift,
    input  logic Dir,
    output logic step_up,
    output logic step_down
);
    import rotary_pkg::*;

    localparam int SW = $clog2(STEPS_PER_DETENT) + 2;
    localparam logic signed [SW-1:0] TOP = SW'(STEPS_PER_DETENT - 1);
    localparam logic signed [SW-1:0] BOT = -TOP;
    localparam logic signed [SW-1:0] ONE = SW'(1);

    logic signed [SW-1:0] sub;

    // The pulse that would reach +/-STEPS_PER_DETENT fires the step and clears Sub in one edge
    assign step_up = Shift && Dir && (sub == TOP);
    assign step_down = Shift && !Dir && (sub == BOT);

    always_ff @(posedge Clk) begin
        if (Reset || step_up || step_down)
            sub <= '0;
        else if (Shift)
            sub <= Dir ? sub + ONE : sub - ONE;
    end
endmodule

// File: rtl/bargraph_level_driver.sv
// bargraph_level_driver: detent-driven level counter with registered bar/dot LED decode
module bargraph_level_driver
    import rotary_pkg::*;
#(
    parameter int LEDS = LEDS_DEFAULT,
    parameter int STEPS_PER_DETENT = STEPS_DEFAULT,
    parameter int WRAP = 0,
    localparam int LW = level_width(LEDS)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Shift,
    input  logic            Dir,
    input  logic            Mode,
    output logic [LEDS-1:0] Leds,
    output logic [LW-1:0]   Level,
    output logic            Limit
);
    localparam logic [LW-1:0] MAXL = LW'(LEDS);
    localparam logic [LW-1:0] ONE = LW'(1);

    logic up, dn, at_top, at_bot, lim_n;
    logic [LW-1:0] lvl_n;
    logic [LEDS-1:0] leds_n;

    detent_accumulator #(.STEPS_PER_DETENT(STEPS_PER_DETENT)) u_acc (
        .Clk(Clk),
        .Reset(Reset),
        .Shift(Shift),
        .Dir(Dir),
        .step_up(up),
        .step_down(dn)
    );

    always_comb begin
        at_top = Level == MAXL;
        at_bot = Level == '0;
        lvl_n = up ? (at_top ? ((WRAP != 0) ? '0 : Level) : Level + ONE)
              : dn ? (at_bot ? ((WRAP != 0) ? MAXL : Level) : Level - ONE)
              : Level;
        lim_n = (WRAP == 0) && ((up && at_top) || (dn && at_bot));
    end

    // Decode from the next-state level so Leds moves on the same edge as Level
    for (genvar i = 0; i < LEDS; i++) begin : g_dec
        assign leds_n[i] = (Mode == MODE_DOT) ? (lvl_n == LW'(i + 1)) : (LW'(i) < lvl_n);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Level <= '0;
            Leds <= '0;
            Limit <= 1'b0;
        end else begin
            Level <= lvl_n;
            Leds <= leds_n;
            Limit <= lim_n;
        end
    end
endmodule

// File: tb/tb_bargraph_level_driver.sv
// tb_bargraph_level_driver: scoreboarded directed+random check of saturating and wrapping instances
module tb_bargraph_level_driver;
    logic Clk, Reset, Shift, Dir, Mode;
    logic [7:0] leds0, leds1;
    logic [3:0] lvl0, lvl1;
    logic lim0, lim1;

    typedef struct {
        logic [7:0] leds;
        logic [3:0] lvl;
        logic       lim;
    } exp_t;

    exp_t q[$];
    int msub[2];
    int mlev[2];
    int limcnt[2];
    int checks = 0;
    int passes = 0;

    bargraph_level_driver #(.WRAP(0)) dut (
        .Clk(Clk), .Reset(Reset), .Shift(Shift), .Dir(Dir), .Mode(Mode),
        .Leds(leds0), .Level(lvl0), .Limit(lim0)
    );

    bargraph_level_driver #(.WRAP(1)) dutw (
        .Clk(Clk), .Reset(Reset), .Shift(Shift), .Dir(Dir), .Mode(Mode),
        .Leds(leds1), .Level(lvl1), .Limit(lim1)
    );

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pattern(input int lev, input logic m);
        if (m) return (lev == 0) ? 8'h00 : 8'(1 << (lev - 1));
        return 8'((1 << lev) - 1);
    endfunction

    task automatic step(input logic s, input logic d, input logic m, input logic r);
        exp_t e;
        Shift = s; Dir = d; Mode = m; Reset = r;
        for (int k = 0; k < 2; k++) begin
            e.lim = 1'b0;
            if (r) begin
                msub[k] = 0;
                mlev[k] = 0;
                e.leds = 8'h00;
            end else begin
                if (s) msub[k] += d ? 1 : -1;
                if (msub[k] == 4) begin
                    msub[k] = 0;
                    if (mlev[k] < 8) mlev[k]++;
                    else if (k == 1) mlev[k] = 0;
                    else e.lim = 1'b1;
                end else if (msub[k] == -4) begin
                    msub[k] = 0;
                    if (mlev[k] > 0) mlev[k]--;
                    else if (k == 1) mlev[k] = 8;
                    else e.lim = 1'b1;
                end
                e.leds = pattern(mlev[k], m);
            end
            e.lvl = 4'(mlev[k]);
            q.push_back(e);
        end
        @(posedge Clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e = q.pop_front();
            chk(k ? "w_leds" : "s_leds", k ? leds1 : leds0, e.leds);
            chk(k ? "w_level" : "s_level", k ? lvl1 : lvl0, e.lvl);
            chk(k ? "w_limit" : "s_limit", k ? lim1 : lim0, e.lim);
        end
        limcnt[0] += lim0;
        limcnt[1] += lim1;
    endtask

    task automatic ups(input int n, input logic m);
        for (int i = 0; i < n; i++) step(1, 1, m, 0);
    endtask

    task automatic downs(input int n, input logic m);
        for (int i = 0; i < n; i++) step(1, 0, m, 0);
    endtask

    initial begin
        Reset = 1; Shift = 0; Dir = 0; Mode = 0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_level", lvl0, 0);
        chk("reset_leds", leds0, 0);

        ups(3, 0);
        chk("no_step_3", lvl0, 0);
        ups(1, 0);
        chk("first_detent_level", lvl0, 1);
        chk("first_detent_leds", leds0, 8'h01);
        chk("first_detent_limit", lim0, 0);

        ups(2, 0); downs(1, 0); ups(2, 0);
        chk("reversal_hold", lvl0, 1);
        ups(1, 0);
        chk("reversal_step", lvl0, 2);

        step(0, 0, 0, 1);
        limcnt[0] = 0; limcnt[1] = 0;
        ups(36, 0);
        chk("sat_level", lvl0, 8);
        chk("sat_leds", leds0, 8'hFF);
        chk("sat_limit_count", limcnt[0], 1);
        chk("wrap_to_zero", lvl1, 0);
        chk("wrap_leds_zero", leds1, 0);
        downs(4, 0);
        chk("sat_down", lvl0, 7);
        chk("wrap_down_to_max", lvl1, 8);
        chk("wrap_no_limit", limcnt[1], 0);
        ups(4, 0);
        chk("wrap_up_again", lvl1, 0);
        downs(4, 0);
        chk("wrap_down_again", lvl1, 8);

        step(0, 0, 0, 1);
        ups(12, 0);
        step(0, 0, 1, 0);
        chk("dot_level3", leds0, 8'h04);
        step(0, 0, 0, 0);
        chk("bar_level3", leds0, 8'h07);

        ups(8, 0);
        ups(3, 0);
        chk("pre_reset_level", lvl0, 5);
        step(1, 1, 0, 1);
        chk("mid_reset_level", lvl0, 0);
        chk("mid_reset_leds", leds0, 0);
        chk("mid_reset_limit", lim0, 0);
        ups(1, 0);
        chk("post_reset_single", lvl0, 0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 63) == 0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
